// File: rtl/div_measure.sv
// Measures period and high-phase length of a slow asynchronous signal in iCLK cycles.
// Result appears the cycle after the closing rising edge is detected; held until iACK.
module div_measure #(
  parameter int          WIDE = 32,
  parameter logic [31:0] TMO  = 32'd1048576
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iSIG,
  input  logic            iSTART,
  input  logic            iACK,
  output logic [WIDE-1:0] oDIV,
  output logic [WIDE-1:0] oHIGH,
  output logic            oVALID,
  output logic            oOVF,
  output logic            oBUSY
);

  localparam logic [WIDE-1:0] TMO_W  = WIDE'(TMO);
  localparam logic [WIDE-1:0] TMO_M1 = WIDE'(TMO - 32'd1);
  localparam logic [WIDE-1:0] ONE    = WIDE'(1);

  typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

  state_t          state;
  logic            sync_1, sync_2, sig_d;
  logic            rise, fall;
  logic [WIDE-1:0] cnt;
  logic [WIDE-1:0] hi_cnt;
  logic            got_fall;

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
      sig_d  <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_1 <= iSIG;
      sync_2 <= sync_1;
      sig_d  <= sync_2;
      rise   <= sync_2 & ~sig_d;
      fall   <= ~sync_2 & sig_d;
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= IDLE;
      cnt      <= '0;
      hi_cnt   <= '0;
      got_fall <= 1'b0;
      oDIV     <= '0;
      oHIGH    <= '0;
      oVALID   <= 1'b0;
      oOVF     <= 1'b0;
      oBUSY    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (iSTART) begin
            state    <= ARM;
            cnt      <= '0;
            hi_cnt   <= '0;
            got_fall <= 1'b0;
            oBUSY    <= 1'b1;
          end
        end
        // cnt doubles as the timeout counter while waiting for the first edge
        ARM: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= ONE;
          end else if (cnt >= TMO_M1) begin
            state  <= DONE;
            oDIV   <= '0;
            oHIGH  <= '0;
            oOVF   <= 1'b1;
            oVALID <= 1'b1;
            oBUSY  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        MEASURE: begin
          if (fall && !got_fall) begin
            hi_cnt   <= cnt;
            got_fall <= 1'b1;
          end
          if (rise) begin
            state  <= DONE;
            oDIV   <= cnt;
            oHIGH  <= hi_cnt;
            oOVF   <= 1'b0;
            oVALID <= 1'b1;
            oBUSY  <= 1'b0;
          end else if (cnt >= TMO_W) begin
            state  <= DONE;
            oDIV   <= '0;
            oHIGH  <= '0;
            oOVF   <= 1'b1;
            oVALID <= 1'b1;
            oBUSY  <= 1'b0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        DONE: begin
          if (iACK) begin
            oVALID <= 1'b0;
            if (iSTART) begin
              state    <= ARM;
              cnt      <= '0;
              hi_cnt   <= '0;
              got_fall <= 1'b0;
              oBUSY    <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_measure.sv
// Scoreboard bench for div_measure: expected results queued at each start, compared on oVALID rise.
module tb_div_measure;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         sig;
  logic         start = 1'b0;
  logic         ack = 1'b0;
  logic [W-1:0] div, high;
  logic         valid, ovf, busy;

  always #5 clk = ~clk;

  div_measure #(.WIDE(W), .TMO(32'd64)) dut (
    .iCLK(clk), .iRST(rst), .iSIG(sig), .iSTART(start), .iACK(ack),
    .oDIV(div), .oHIGH(high), .oVALID(valid), .oOVF(ovf), .oBUSY(busy)
  );

  typedef struct packed {
    logic [W-1:0] div;
    logic [W-1:0] high;
    logic         ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int d, input int h, input bit o);
    exp_t e;
    e.div  = d;
    e.high = h;
    e.ovf  = o;
    return e;
  endfunction

  // Square-wave source, edges placed on the falling iCLK edge
  bit   gen_on = 1'b0;
  int   gen_hi = 2;
  int   gen_lo = 2;
  logic gen_lvl = 1'b0;

  initial forever begin
    if (gen_on) begin
      sig = 1'b1;
      repeat (gen_hi) @(negedge clk);
      sig = 1'b0;
      repeat (gen_lo) @(negedge clk);
    end else begin
      sig = gen_lvl;
      @(negedge clk);
    end
  end

  logic prev_valid = 1'b0;

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (valid && !prev_valid) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("div", div, e.div);
        chk("high", high, e.high);
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    prev_valid = valid;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_sig(input int hi, input int lo);
    gen_hi = hi;
    gen_lo = lo;
    gen_on = 1'b1;
    cycles(3 * (hi + lo));
  endtask

  task automatic start_meas(input exp_t e);
    @(negedge clk);
    start = 1'b1;
    sb_q.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (!valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(valid), 32'd1);
  endtask

  task automatic ack_it();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("valid_low_after_ack", 32'(valid), 32'd0);
  endtask

  initial begin
    int n;
    cycles(3);
    chk("rst_div", div, 0);
    chk("rst_high", high, 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_busy", 32'(busy), 0);
    rst = 1'b0;
    cycles(2);

    // divide-by-4 clock
    set_sig(2, 2);
    start_meas(mk(4, 2, 0));
    chk("busy_arm", 32'(busy), 1);
    wait_valid("valid_div4");
    chk("busy_done", 32'(busy), 0);
    ack_it();
    chk("busy_idle", 32'(busy), 0);

    // period 7, result held while unacknowledged
    set_sig(3, 4);
    start_meas(mk(7, 3, 0));
    wait_valid("valid_div7");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(valid), 1);
      chk("hold_div", div, 7);
      chk("hold_high", high, 3);
    end
    ack_it();

    // stuck-low input times out in ARM
    gen_on = 1'b0;
    gen_lvl = 1'b0;
    cycles(20);
    start_meas(mk(0, 0, 1));
    chk("busy_tmo", 32'(busy), 1);
    n = 0;
    while (!valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_cycles", n, 64);
    ack_it();
    chk("busy_after_tmo", 32'(busy), 0);

    // divide-by-10 with stray start and back-to-back restart
    set_sig(5, 5);
    start_meas(mk(10, 5, 0));
    cycles(4);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid("valid_div10_a");
    @(negedge clk);
    ack = 1'b1;
    start = 1'b1;
    sb_q.push_back(mk(10, 5, 0));
    @(negedge clk);
    ack = 1'b0;
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_valid", 32'(valid), 0);
    wait_valid("valid_div10_b");
    ack_it();
    cycles(5);
    chk("no_extra_busy", 32'(busy), 0);

    // reset in the middle of MEASURE
    gen_on = 1'b0;
    gen_lvl = 1'b0;
    cycles(20);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles(2);
    gen_lvl = 1'b1;
    cycles(6);
    chk("busy_measure", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_div", div, 0);
    chk("arst_high", high, 0);
    chk("arst_valid", 32'(valid), 0);
    chk("arst_ovf", 32'(ovf), 0);
    chk("arst_busy", 32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    gen_hi = 2;
    gen_lo = 2;
    gen_on = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_valid", 32'(valid), 0);
    end
    start_meas(mk(4, 2, 0));
    wait_valid("valid_after_rst");
    ack_it();

    cycles(5);
    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
